pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Owns the fetch PC register and selects next PC. Arbitrates redirects from MEM (eret, exception,
//  TLB refill, TLBWI/TLBR refetch) and ID (branch, jump, jump-register).
//  Redirects arriving while fetch is stalled are held, never dropped. Sits between IF and ID/MEM control.
// PARAMETERS
//  ADDR_W      32             PC / target width
//  RESET_PC    32'hBFC0_0000  PC value after reset
//  EXC_VEC     32'hBFC0_0380  general exception entry
//  REFILL_VEC  32'hBFC0_0200  TLB-refill exception entry
//  ERET_OFS    4              added to EPC on eret
//  CNT_W       16             width of redirect performance counters (saturating)
// PORTS
//  clk          in   1       the single clock; all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  pc_wr        in   1       fetch may advance this cycle (0 = IF stall)
//  npc_op       in   2       ID: 00 seq, 01 branch, 10 jump, 11 jump-register
//  id_pc        in   ADDR_W  PC of ID-stage control instruction
//  imm26        in   26      ID immediate (branch uses [15:0])
//  ret_addr     in   ADDR_W  ID jump-register target
//  mem_eret     in   1       MEM eret flush pulse
//  mem_ex       in   1       MEM exception pulse
//  mem_refill   in   1       qualifies mem_ex as TLB refill
//  epc          in   ADDR_W  CP0 EPC
//  wb_tlb_flush in   1       WB TLBWI/TLBR refetch pulse
//  wb_pc        in   ADDR_W  refetch target for wb_tlb_flush
//  pc           out  ADDR_W  current fetch PC (registered)
//  front_flush  out  1       flush IF/ID/EX (exception-class redirect)
//  pc_flush     out  1       any redirect taken this cycle
//  pend         out  1       redirect held awaiting pc_wr
//  exc_cnt      out  CNT_W   exception-class redirects applied
//  br_cnt       out  CNT_W   branch/jump redirects applied
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state IDLE, pend=0, counters=0, flushes=0.
//  Priority (high->low): mem_eret > mem_ex > wb_tlb_flush > held redirect > ID npc_op != 00 > PC+4.
//  Targets: eret=epc+ERET_OFS; ex=mem_refill?REFILL_VEC:EXC_VEC; tlb=wb_pc;
//   branch=id_pc+{sext(imm26[15:0]),2'b00}; jump={id_pc[31:28],imm26,2'b00}; jr=ret_addr.
//  All adds are modulo 2^ADDR_W (wrap, no trap).
//  FSM IDLE: winning redirect with pc_wr=1 -> pc<=target next edge, stay IDLE.
//   Winning redirect with pc_wr=0 -> latch target+class, go HOLD.
//   No redirect: pc<=pc+4 iff pc_wr.
//  FSM HOLD: pend=1. New MEM-class event overwrites the held target (any held class).
//   ID redirects are ignored while holding. On pc_wr=1: pc<=held target (or new MEM target), go IDLE.
//  front_flush: combinational; 1 in the cycle a MEM-class event is present, regardless of pc_wr.
//  pc_flush: combinational; 1 when a redirect is applied (pc_wr=1 with winner or HOLD release).
//   Also 1 when a MEM-class event is present.
//  Counters increment once per applied redirect (at pc load), by class. Saturate at all-ones.
//  Reset mid-HOLD discards the held target; fetch restarts at RESET_PC.
//  Latency: redirect at cycle t with pc_wr=1 -> pc=target at t+1.
// STRUCTURE
//  Shared package mips_pkg: NPC_SEQ/BR/J/JR opcodes, redir_class_e {NONE,BR,TLB,EXC,ERET}, vectors.
//  One sub-module: pc_target_calc (pure combinational target + priority select).
//  FSM, hold register, PC register and counters stay in this top.
// TESTING
//  1. Reset release, pc_wr=1 for 3 cycles -> pc BFC0_0000, _0004, _0008, _000C; counters 0.
//  2. npc_op=01, id_pc=8000_0010, imm=FFFC, pc_wr=1 -> next pc=8000_0000; br_cnt=1; pc_flush=1 once.
//  3. mem_ex+mem_refill with pc_wr=0 for 2 cycles -> pend=1, front_flush=1 in pulse cycle.
//     Then pc_wr=1 -> pc=BFC0_0200, pend=0, exc_cnt=1.
//  4. Same-cycle mem_eret(epc=8000_1000), mem_ex, npc_op=10 -> pc=8000_1004; one exc_cnt increment.
//  5. HOLD with branch target; mem_ex arrives -> held target replaced; release -> pc=BFC0_0380;
//     br_cnt unchanged.
//  6. rst_n low mid-HOLD asynchronously -> pc=BFC0_0000 immediately; pend=0.
//     Wrap check: id_pc=FFFF_FFFC, seq -> 0000_0000.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_unit_pkg
// Purpose : Shared opcodes, redirect classes, FSM states and default vectors
//           for the fetch PC redirect unit.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pc_redirect_unit_pkg;

    // ID next-PC opcodes
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Default reset / exception vectors
    localparam logic [31:0] C_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] C_EXC_VEC    = 32'hBFC0_0380;
    localparam logic [31:0] C_REFILL_VEC = 32'hBFC0_0200;
    localparam int          C_ERET_OFS   = 4;

    // Redirect class, ordered so that anything above BR is exception-class
    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_BR   = 3'd1,
        RC_TLB  = 3'd2,
        RC_EXC  = 3'd3,
        RC_ERET = 3'd4
    } redir_class_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_e;

    // eret, exception and TLB refetch all count and flush as exception-class
    function automatic logic is_exc_class(input redir_class_e cls);
        return (cls == RC_TLB) || (cls == RC_EXC) || (cls == RC_ERET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_unit_if
// Purpose : Bundles the ID / MEM / WB redirect requests and the fetch-side
//           results of the PC redirect unit.
// Ports   : master modport - pipeline control side (drives requests)
//           slave  modport - pc_redirect_unit (drives pc, flushes, counters)
// Revision: 1.0 - initial release
// ============================================================================
interface pc_redirect_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              pc_wr;
    logic [1:0]        npc_op;
    logic [ADDR_W-1:0] id_pc;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] ret_addr;
    logic              mem_eret;
    logic              mem_ex;
    logic              mem_refill;
    logic [ADDR_W-1:0] epc;
    logic              wb_tlb_flush;
    logic [ADDR_W-1:0] wb_pc;
    logic [ADDR_W-1:0] pc;
    logic              front_flush;
    logic              pc_flush;
    logic              pend;
    logic [CNT_W-1:0]  exc_cnt;
    logic [CNT_W-1:0]  br_cnt;

    modport master (
        output pc_wr, npc_op, id_pc, imm26, ret_addr,
               mem_eret, mem_ex, mem_refill, epc, wb_tlb_flush, wb_pc,
        input  pc, front_flush, pc_flush, pend, exc_cnt, br_cnt
    );

    modport slave (
        input  pc_wr, npc_op, id_pc, imm26, ret_addr,
               mem_eret, mem_ex, mem_refill, epc, wb_tlb_flush, wb_pc,
        output pc, front_flush, pc_flush, pend, exc_cnt, br_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_unit_target_calc.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_unit_target_calc
// Purpose : Pure combinational target computation and priority select
//           (eret > exception > TLB refetch > held > ID redirect).
// Ports   : ID/MEM/WB request fields and held redirect in;
//           mem_event, win_valid, win_target, win_class out.
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_unit_target_calc
    import pc_redirect_unit_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC    = C_EXC_VEC,
    parameter logic [ADDR_W-1:0] REFILL_VEC = C_REFILL_VEC,
    parameter int              ERET_OFS   = C_ERET_OFS
) (
    input  wire logic [1:0]        npc_op,
    input  wire logic [ADDR_W-1:0] id_pc,
    input  wire logic [25:0]       imm26,
    input  wire logic [ADDR_W-1:0] ret_addr,
    input  wire logic              mem_eret,
    input  wire logic              mem_ex,
    input  wire logic              mem_refill,
    input  wire logic [ADDR_W-1:0] epc,
    input  wire logic              wb_tlb_flush,
    input  wire logic [ADDR_W-1:0] wb_pc,
    input  wire logic              held_valid,
    input  wire logic [ADDR_W-1:0] held_target,
    input  redir_class_e           held_class,
    output logic                   mem_event,
    output logic                   win_valid,
    output logic [ADDR_W-1:0]      win_target,
    output redir_class_e           win_class
);

    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_eret_target;

    // All adds wrap modulo 2^ADDR_W
    assign w_br_target   = id_pc + {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
    assign w_j_target    = {id_pc[ADDR_W-1:28], imm26, 2'b00};
    assign w_eret_target = epc + ADDR_W'(ERET_OFS);

    assign mem_event = mem_eret | mem_ex | wb_tlb_flush;

    always_comb begin
        win_valid  = 1'b1;
        win_target = '0;
        win_class  = RC_NONE;
        if (mem_eret) begin
            win_target = w_eret_target;
            win_class  = RC_ERET;
        end else if (mem_ex) begin
            win_target = mem_refill ? REFILL_VEC : EXC_VEC;
            win_class  = RC_EXC;
        end else if (wb_tlb_flush) begin
            win_target = wb_pc;
            win_class  = RC_TLB;
        end else if (held_valid) begin
            // A held redirect outranks ID, so ID requests are ignored in HOLD
            win_target = held_target;
            win_class  = held_class;
        end else begin
            case (npc_op)
                NPC_BR: begin
                    win_target = w_br_target;
                    win_class  = RC_BR;
                end
                NPC_J: begin
                    win_target = w_j_target;
                    win_class  = RC_BR;
                end
                NPC_JR: begin
                    win_target = ret_addr;
                    win_class  = RC_BR;
                end
                default: win_valid = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_unit
// Purpose : Owns the fetch PC, applies prioritised redirects and holds any
//           redirect that arrives while fetch is stalled until pc_wr.
// Ports   : clk, rst_n (async active-low)
//           bus (slave) - pc_wr, ID/MEM/WB redirect requests in;
//                         pc, front_flush, pc_flush, pend, exc_cnt, br_cnt out
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = C_RESET_PC,
    parameter logic [ADDR_W-1:0] EXC_VEC    = C_EXC_VEC,
    parameter logic [ADDR_W-1:0] REFILL_VEC = C_REFILL_VEC,
    parameter int                ERET_OFS   = C_ERET_OFS,
    parameter int                CNT_W      = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pc_redirect_unit_if.slave bus
);

    fsm_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_hold_target;
    redir_class_e      r_hold_class;
    logic [CNT_W-1:0]  r_exc_cnt;
    logic [CNT_W-1:0]  r_br_cnt;

    logic              w_mem_event;
    logic              w_win_valid;
    logic [ADDR_W-1:0] w_win_target;
    redir_class_e      w_win_class;
    logic              w_apply;

    pc_redirect_unit_target_calc #(
        .ADDR_W     (ADDR_W),
        .EXC_VEC    (EXC_VEC),
        .REFILL_VEC (REFILL_VEC),
        .ERET_OFS   (ERET_OFS)
    ) u_target_calc (
        .npc_op       (bus.npc_op),
        .id_pc        (bus.id_pc),
        .imm26        (bus.imm26),
        .ret_addr     (bus.ret_addr),
        .mem_eret     (bus.mem_eret),
        .mem_ex       (bus.mem_ex),
        .mem_refill   (bus.mem_refill),
        .epc          (bus.epc),
        .wb_tlb_flush (bus.wb_tlb_flush),
        .wb_pc        (bus.wb_pc),
        .held_valid   (r_state == ST_HOLD),
        .held_target  (r_hold_target),
        .held_class   (r_hold_class),
        .mem_event    (w_mem_event),
        .win_valid    (w_win_valid),
        .win_target   (w_win_target),
        .win_class    (w_win_class)
    );

    // In HOLD the held redirect is always a valid winner, so a release is
    // simply a winner with pc_wr asserted.
    assign w_apply = w_win_valid & bus.pc_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_hold_target <= '0;
            r_hold_class  <= RC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        if (bus.pc_wr) begin
                            r_pc <= w_win_target;
                        end else begin
                            r_hold_target <= w_win_target;
                            r_hold_class  <= w_win_class;
                            r_state       <= ST_HOLD;
                        end
                    end else if (bus.pc_wr) begin
                        r_pc <= r_pc + ADDR_W'(4);
                    end
                end
                ST_HOLD: begin
                    if (bus.pc_wr) begin
                        r_pc    <= w_win_target;
                        r_state <= ST_IDLE;
                    end else begin
                        // A new MEM-class event replaces the held target;
                        // otherwise the winner is the held entry itself.
                        r_hold_target <= w_win_target;
                        r_hold_class  <= w_win_class;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_cnt <= '0;
            r_br_cnt  <= '0;
        end else if (w_apply) begin
            if (is_exc_class(w_win_class) && (r_exc_cnt != '1)) begin
                r_exc_cnt <= r_exc_cnt + 1'b1;
            end
            if ((w_win_class == RC_BR) && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pend        = (r_state == ST_HOLD);
    assign bus.front_flush = w_mem_event;
    assign bus.pc_flush    = w_apply | w_mem_event;
    assign bus.exc_cnt     = r_exc_cnt;
    assign bus.br_cnt      = r_br_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_redirect_unit
// Purpose : Self-checking bench for pc_redirect_unit; expected register state
//           is queued per stimulus cycle and compared after the clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    logic clk;
    logic rst_n;

    pc_redirect_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    pc_redirect_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [15:0] exc;
        logic [15:0] br;
        string       tag;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_hold_t;
    bit          m_hold_exc;
    logic [15:0] m_exc;
    logic [15:0] m_br;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'hBFC0_0000;
        m_hold     = 0;
        m_hold_t   = '0;
        m_hold_exc = 0;
        m_exc      = '0;
        m_br       = '0;
    endtask

    // One stimulus cycle: drive, check combinational flags, queue expectations
    task automatic step(input string tag, input bit wr, input logic [1:0] op,
                        input logic [31:0] idpc, input logic [25:0] imm,
                        input logic [31:0] ra, input bit eret, input bit ex,
                        input bit refill, input logic [31:0] epc_v,
                        input bit tlb, input logic [31:0] wbpc_v);
        bit          mem, win, cls_exc;
        logic [31:0] t;
        logic [31:0] boff;
        exp_t        e;
        bus.pc_wr = wr; bus.npc_op = op; bus.id_pc = idpc; bus.imm26 = imm;
        bus.ret_addr = ra; bus.mem_eret = eret; bus.mem_ex = ex;
        bus.mem_refill = refill; bus.epc = epc_v; bus.wb_tlb_flush = tlb;
        bus.wb_pc = wbpc_v;
        #1;
        mem = eret || ex || tlb;
        win = 1; cls_exc = 1; t = '0;
        boff = {{14{imm[15]}}, imm[15:0], 2'b00};
        if (eret)         t = epc_v + 32'd4;
        else if (ex)      t = refill ? 32'hBFC0_0200 : 32'hBFC0_0380;
        else if (tlb)     t = wbpc_v;
        else if (m_hold) begin t = m_hold_t; cls_exc = m_hold_exc; end
        else begin
            cls_exc = 0;
            case (op)
                2'b01:   t = idpc + boff;
                2'b10:   t = {idpc[31:28], imm, 2'b00};
                2'b11:   t = ra;
                default: win = 0;
            endcase
        end
        chk({tag, "/front_flush"}, bus.front_flush, mem);
        chk({tag, "/pc_flush"}, bus.pc_flush, (win && wr) || mem);
        if (win && wr) begin
            m_pc = t; m_hold = 0;
            if (cls_exc) m_exc++; else m_br++;
        end else if (win) begin
            m_hold = 1; m_hold_t = t; m_hold_exc = cls_exc;
        end else if (wr) begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.pend = m_hold; e.exc = m_exc; e.br = m_br; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input string tag, input bit wr);
        step(tag, wr, 2'b00, '0, '0, '0, 0, 0, 0, '0, 0, '0);
    endtask

    // Scoreboard monitor: compares queued expectations just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "/pc"},      bus.pc,      e.pc);
                chk({e.tag, "/pend"},    bus.pend,    e.pend);
                chk({e.tag, "/exc_cnt"}, bus.exc_cnt, e.exc);
                chk({e.tag, "/br_cnt"},  bus.br_cnt,  e.br);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.pc_wr = 0; bus.npc_op = 2'b00; bus.id_pc = '0; bus.imm26 = '0;
        bus.ret_addr = '0; bus.mem_eret = 0; bus.mem_ex = 0; bus.mem_refill = 0;
        bus.epc = '0; bus.wb_tlb_flush = 0; bus.wb_pc = '0;
        model_reset();
        #22;
        chk("rst/pc", bus.pc, 32'hBFC0_0000);
        chk("rst/pend", bus.pend, 1'b0);
        chk("rst/exc_cnt", bus.exc_cnt, 16'd0);
        chk("rst/br_cnt", bus.br_cnt, 16'd0);
        chk("rst/pc_flush", bus.pc_flush, 1'b0);
        chk("rst/front_flush", bus.front_flush, 1'b0);
        rst_n = 1'b1;

        // 1: sequential fetch
        for (int i = 0; i < 3; i++) idle("t1_seq", 1);
        chk("t1/pc", bus.pc, 32'hBFC0_000C);

        // 2: backward branch
        step("t2_br", 1, 2'b01, 32'h8000_0010, 26'h000FFFC, '0, 0, 0, 0, '0, 0, '0);
        chk("t2/pc", bus.pc, 32'h8000_0000);
        chk("t2/br_cnt", bus.br_cnt, 16'd1);
        idle("t2_stall", 0);

        // 3: refill exception while stalled, then release
        step("t3_ex", 0, 2'b00, '0, '0, '0, 0, 1, 1, '0, 0, '0);
        idle("t3_stall", 0);
        idle("t3_rel", 1);
        chk("t3/pc", bus.pc, 32'hBFC0_0200);
        chk("t3/exc_cnt", bus.exc_cnt, 16'd1);

        // 4: eret beats exception and jump in the same cycle
        step("t4_eret", 1, 2'b10, 32'h9000_0000, 26'h0000100, '0, 1, 1, 0,
             32'h8000_1000, 0, '0);
        chk("t4/pc", bus.pc, 32'h8000_1004);
        chk("t4/exc_cnt", bus.exc_cnt, 16'd2);

        // 5: held branch, ignored JR, then replaced by exception
        step("t5_br", 0, 2'b01, 32'h8000_0010, 26'h000FFFC, '0, 0, 0, 0, '0, 0, '0);
        step("t5_jr", 0, 2'b11, '0, '0, 32'h1234_5678, 0, 0, 0, '0, 0, '0);
        step("t5_ex", 0, 2'b00, '0, '0, '0, 0, 1, 0, '0, 0, '0);
        idle("t5_rel", 1);
        chk("t5/pc", bus.pc, 32'hBFC0_0380);
        chk("t5/br_cnt", bus.br_cnt, 16'd1);

        // TLB refetch and a held jump released normally
        step("t5_tlb", 1, 2'b00, '0, '0, '0, 0, 0, 0, '0, 1, 32'h0040_0000);
        step("t5_j", 0, 2'b10, 32'hA000_0000, 26'h0000040, '0, 0, 0, 0, '0, 0, '0);
        idle("t5_jrel", 1);
        chk("t5/j_pc", bus.pc, 32'hA000_0100);

        // 6: asynchronous reset in HOLD
        step("t6_hold", 0, 2'b01, 32'h8000_0010, 26'h0000004, '0, 0, 0, 0, '0, 0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6/pc", bus.pc, 32'hBFC0_0000);
        chk("t6/pend", bus.pend, 1'b0);
        chk("t6/exc_cnt", bus.exc_cnt, 16'd0);
        model_reset();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        idle("t6_after", 1);

        // wrap-around of sequential and branch adds
        step("wrap_jr", 1, 2'b11, '0, '0, 32'hFFFF_FFFC, 0, 0, 0, '0, 0, '0);
        idle("wrap_seq", 1);
        chk("wrap/pc", bus.pc, 32'h0000_0000);
        step("wrap_br", 1, 2'b01, 32'hFFFF_FFF0, 26'h0000008, '0, 0, 0, 0, '0, 0, '0);
        chk("wrap/br_pc", bus.pc, 32'h0000_0010);

        @(posedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
